// File: rtl/pc_sel_ctrl_if.sv
// Request/response bundle between the pipeline control and the next-PC source controller.
// The master side raises stall and redirect requests; the slave side drives the mux select and the pipeline enables.
interface pc_sel_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             freeze;
   logic             hazard_stall;
   logic             branch_taken_ex;
   logic             jump_id;
   logic             jr_id;
   logic [2:0]       pc_sel;
   logic             pc_write;
   logic             ifid_write;
   logic             ifid_flush;
   logic             idex_flush;
   logic [CNT_W-1:0] redirect_cnt;
   logic             err;

   modport master (
      output freeze, hazard_stall, branch_taken_ex, jump_id, jr_id,
      input  pc_sel, pc_write, ifid_write, ifid_flush, idex_flush, redirect_cnt, err
   );

   modport slave (
      input  freeze, hazard_stall, branch_taken_ex, jump_id, jr_id,
      output pc_sel, pc_write, ifid_write, ifid_flush, idex_flush, redirect_cnt, err
   );
endinterface

// File: rtl/pc_sel_ctrl.sv
// Next-PC source controller: prioritises EX/ID redirects against stalls, drives the one-hot
// next-PC mux select and pipeline enables, and holds a frozen redirect until the freeze lifts.
module pc_sel_ctrl #(
   parameter int CNT_W      = 16,
   parameter bit DELAY_SLOT = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   pc_sel_ctrl_if.slave bus
);
   typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

   localparam logic [2:0] SEL_SEQ = 3'b000;
   localparam logic [2:0] SEL_BR  = 3'b001;
   localparam logic [2:0] SEL_J   = 3'b010;
   localparam logic [2:0] SEL_JR  = 3'b100;

   state_t           state_r, state_s;
   logic [2:0]       latched_r, latched_s;
   logic [CNT_W-1:0] cnt_r;
   logic             err_r;

   logic [2:0]       req_s;
   logic [2:0]       sel_s;
   logic             pc_write_s, ifid_write_s, ifid_flush_s, idex_flush_s;
   logic             commit_s;

   // Flushes owed by a committed redirect: {ifid_flush, idex_flush}.
   function automatic logic [1:0] flush_of(input logic [2:0] code);
      logic [1:0] f;
      case (code)
         SEL_BR:         f = 2'b11;
         SEL_J, SEL_JR:  f = {~DELAY_SLOT, 1'b0};
         default:        f = 2'b00;
      endcase
      return f;
   endfunction

   // Prioritised request code; a hazard stall suppresses ID requests but never a branch.
   always_comb begin
      req_s = SEL_SEQ;
      if (bus.branch_taken_ex) begin
         req_s = SEL_BR;
      end else if (bus.hazard_stall) begin
         req_s = SEL_SEQ;
      end else if (bus.jr_id) begin
         req_s = SEL_JR;
      end else if (bus.jump_id) begin
         req_s = SEL_J;
      end else begin
         req_s = SEL_SEQ;
      end
   end

   // Next-state and output decode.
   always_comb begin
      state_s      = state_r;
      latched_s    = latched_r;
      sel_s        = SEL_SEQ;
      pc_write_s   = 1'b0;
      ifid_write_s = 1'b0;
      ifid_flush_s = 1'b0;
      idex_flush_s = 1'b0;
      commit_s     = 1'b0;
      case (state_r)
         RUN: begin
            if (bus.freeze) begin
               sel_s = req_s;
               if (req_s != SEL_SEQ) begin
                  latched_s = req_s;
                  state_s   = HOLD;
               end else begin
                  latched_s = latched_r;
               end
            end else if (!bus.branch_taken_ex && bus.hazard_stall) begin
               idex_flush_s = 1'b1;
            end else begin
               sel_s        = req_s;
               pc_write_s   = 1'b1;
               ifid_write_s = 1'b1;
               {ifid_flush_s, idex_flush_s} = flush_of(req_s);
               commit_s     = (req_s != SEL_SEQ);
            end
         end
         HOLD: begin
            sel_s = latched_r;
            if (!bus.freeze) begin
               pc_write_s   = 1'b1;
               ifid_write_s = 1'b1;
               {ifid_flush_s, idex_flush_s} = flush_of(latched_r);
               commit_s     = 1'b1;
               state_s      = RUN;
            end else begin
               state_s = HOLD;
            end
         end
         default: begin
            state_s = RUN;
         end
      endcase
   end

   // State, latched code, saturating counter and sticky error.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= RUN;
         latched_r <= SEL_SEQ;
         cnt_r     <= {CNT_W{1'b0}};
         err_r     <= 1'b0;
      end else begin
         state_r   <= state_s;
         latched_r <= latched_s;
         if (commit_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end
         err_r <= err_r | (bus.jump_id & bus.jr_id);
      end
   end

   // Everything reads as zero while reset is held, including the not-yet-cleared registers.
   assign bus.pc_sel       = rst_n ? sel_s : SEL_SEQ;
   assign bus.pc_write     = rst_n & pc_write_s;
   assign bus.ifid_write   = rst_n & ifid_write_s;
   assign bus.ifid_flush   = rst_n & ifid_flush_s;
   assign bus.idex_flush   = rst_n & idex_flush_s;
   assign bus.redirect_cnt = rst_n ? cnt_r : {CNT_W{1'b0}};
   assign bus.err          = rst_n & err_r;
endmodule
